// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// It sits between the memory stage and data memory and stalls the pipeline on refills and stores.
module data_cache_lane #(
    parameter int W = 8
) (
    input  logic         en,
    input  logic [W-1:0] old_b,
    input  logic [W-1:0] new_b,
    output logic [W-1:0] out_b
);
    assign out_b = en ? new_b : old_b;
endmodule

module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [3:0]            byte_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_byte_en_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [31:0]           hit_count_o,
    output logic [31:0]           miss_count_o
);
    localparam int IDX    = $clog2(SETS);
    localparam int TAG_W  = DATA_WIDTH - IDX - 2;
    localparam int LANE_W = DATA_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;

    state_t state, state_nxt;
    logic   was_refill;

    logic [SETS-1:0]                  valid;
    logic [SETS-1:0][TAG_W-1:0]       tag_mem;
    logic [SETS-1:0][DATA_WIDTH-1:0]  data_mem;

    logic [IDX-1:0]        idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic [DATA_WIDTH-1:0] merged;
    logic                  unused_addr;

    assign idx         = addr_i[IDX+1:2];
    assign tag         = addr_i[DATA_WIDTH-1:IDX+2];
    assign hit         = valid[idx] && (tag_mem[idx] == tag);
    assign rd_data_o   = data_mem[idx];
    assign unused_addr = ^addr_i[1:0];

    data_cache_lane #(.W(LANE_W)) u_lane [3:0] (
        .en    (byte_en_i),
        .old_b (data_mem[idx]),
        .new_b (wr_data_i),
        .out_b (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (wr_en_i)   state_nxt = WRITE;
                    else if (!hit) state_nxt = REFILL;
                end
            end
            REFILL: if (mem_ack_i) state_nxt = IDLE;
            WRITE:  if (mem_ack_i) state_nxt = WDONE;
            WDONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        case (state)
            IDLE:          stall_o = req_i && (wr_en_i || !hit);
            REFILL, WRITE: stall_o = 1'b1;
            default:       stall_o = 1'b0;
        endcase
    end

    // Control, bus registers and counters; the post-refill retry is not counted as a hit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid         <= '0;
            was_refill    <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_byte_en_o <= '0;
            hit_count_o   <= '0;
            miss_count_o  <= '0;
        end else begin
            was_refill <= (state == REFILL);
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (wr_en_i) begin
                            mem_req_o     <= 1'b1;
                            mem_we_o      <= 1'b1;
                            mem_addr_o    <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_wdata_o   <= wr_data_i;
                            mem_byte_en_o <= byte_en_i;
                        end else if (!hit) begin
                            mem_req_o     <= 1'b1;
                            mem_we_o      <= 1'b0;
                            mem_addr_o    <= {addr_i[DATA_WIDTH-1:2], 2'b00};
                            mem_byte_en_o <= 4'b1111;
                            miss_count_o  <= miss_count_o + 32'd1;
                        end else if (!was_refill) begin
                            hit_count_o   <= hit_count_o + 32'd1;
                        end
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        valid[idx] <= 1'b1;
                        mem_req_o  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        mem_we_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst && mem_ack_i) begin
            if (state == REFILL) begin
                tag_mem[idx]  <= tag;
                data_mem[idx] <= mem_rdata_i;
            end else if (state == WRITE && hit) begin
                data_mem[idx] <= merged;
            end
        end
    end
endmodule
